// File: rtl/arb_pkg.sv
// Shared definitions for the I/D cache arbiter slice.
//   - ADDR_W_DEF / LINE_W_DEF : default byte-address and cacheline widths
//   - arb_state_e             : arbiter FSM states
//   - req_e                   : requester identity, also used as the
//                               last-grant pointer
//   - gnt_idx                 : maps a requester to its bit in the
//                               picker's request/grant vectors
package arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    GAP     = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_e;

  // Bit position of a requester in the 2-bit request/grant vectors.
  function automatic int gnt_idx(input req_e r);
    return (r == REQ_I) ? 0 : 1;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// 2-way round-robin picker, purely combinational.
// Ports:
//   req  [1:0] : pending requests, bit 0 = I-cache, bit 1 = D-cache
//   last       : requester granted most recently
//   gnt  [1:0] : one-hot grant (all zero when nothing is pending)
// On a tie the requester that was not granted last wins.
module rr_pick2
  import arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_e       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == REQ_D) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache line fills and D-cache fills/writebacks onto a single
// cacheline adaptor port.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   icache_read_i/address_i      : I-cache fill request
//   icache_line_o/resp_o         : I-cache fill data and completion pulse
//   dcache_read_i/write_i        : D-cache fill / writeback request
//   dcache_address_i/line_i      : D-cache address and writeback data
//   dcache_line_o/resp_o         : D-cache fill data and completion pulse
//   pmem_read_o/write_o          : request to the adaptor
//   pmem_address_o/line_o        : latched address / writeback line
//   pmem_line_i/resp_i           : adaptor fill data and completion pulse
// One transfer at a time: IDLE picks a requester, SERVE_x holds the
// latched request on the adaptor until pmem_resp_i, then a one-cycle GAP
// lets both the adaptor and the requester return to idle.
module cache_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              icache_read_i,
  input  logic [ADDR_W-1:0] icache_address_i,
  output logic [LINE_W-1:0] icache_line_o,
  output logic              icache_resp_o,

  input  logic              dcache_read_i,
  input  logic              dcache_write_i,
  input  logic [ADDR_W-1:0] dcache_address_i,
  input  logic [LINE_W-1:0] dcache_line_i,
  output logic [LINE_W-1:0] dcache_line_o,
  output logic              dcache_resp_o,

  output logic              pmem_read_o,
  output logic              pmem_write_o,
  output logic [ADDR_W-1:0] pmem_address_o,
  output logic [LINE_W-1:0] pmem_line_o,
  input  logic [LINE_W-1:0] pmem_line_i,
  input  logic              pmem_resp_i
);

  arb_state_e        state, state_nxt;
  req_e              last_gnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [LINE_W-1:0] lat_line;
  logic              lat_wr;

  logic [1:0]        req, gnt;
  logic              serving, grant_i, grant_d;

  // A D-cache read+write pair counts as one request; the write is taken
  // first and the read shows up again as a fresh request after GAP.
  assign req = {dcache_read_i | dcache_write_i, icache_read_i};

  rr_pick2 u_pick (
    .req  (req),
    .last (last_gnt),
    .gnt  (gnt)
  );

  assign grant_i = (state == IDLE) && gnt[gnt_idx(REQ_I)];
  assign grant_d = (state == IDLE) && gnt[gnt_idx(REQ_D)];
  assign serving = (state == SERVE_I) || (state == SERVE_D);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_i)      state_nxt = SERVE_I;
        else if (grant_d) state_nxt = SERVE_D;
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp_i) state_nxt = GAP;
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= REQ_D;  // I-cache wins the first tie
      lat_addr <= '0;
      lat_line <= '0;
      lat_wr   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_i) begin
        // I-cache is read-only; the writeback line keeps its old value.
        lat_addr <= icache_address_i;
        lat_wr   <= 1'b0;
      end else if (grant_d) begin
        lat_addr <= dcache_address_i;
        lat_wr   <= dcache_write_i;
        lat_line <= dcache_line_i;
      end
      if (serving && pmem_resp_i)
        last_gnt <= (state == SERVE_I) ? REQ_I : REQ_D;
    end
  end

  // Everything is forced low while rst is high, so a transfer caught by
  // reset is dropped in that very cycle and never produces a resp pulse.
  always_comb begin
    pmem_read_o    = !rst && serving && !lat_wr;
    pmem_write_o   = !rst && serving &&  lat_wr;
    pmem_address_o = rst ? '0 : lat_addr;
    pmem_line_o    = rst ? '0 : lat_line;

    icache_resp_o  = !rst && (state == SERVE_I) && pmem_resp_i;
    dcache_resp_o  = !rst && (state == SERVE_D) && pmem_resp_i;

    icache_line_o  = icache_resp_o ? pmem_line_i : '0;
    // Only fills carry data back; a writeback completion returns zero.
    dcache_line_o  = (dcache_resp_o && !lat_wr) ? pmem_line_i : '0;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         icache_read_i;
  logic [31:0]  icache_address_i;
  logic [255:0] icache_line_o;
  logic         icache_resp_o;
  logic         dcache_read_i, dcache_write_i;
  logic [31:0]  dcache_address_i;
  logic [255:0] dcache_line_i, dcache_line_o;
  logic         dcache_resp_o;
  logic         pmem_read_o, pmem_write_o;
  logic [31:0]  pmem_address_o;
  logic [255:0] pmem_line_o, pmem_line_i;
  logic         pmem_resp_i;

  always #5 clk = ~clk;

  cache_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
    .clk(clk), .rst(rst),
    .icache_read_i(icache_read_i), .icache_address_i(icache_address_i),
    .icache_line_o(icache_line_o), .icache_resp_o(icache_resp_o),
    .dcache_read_i(dcache_read_i), .dcache_write_i(dcache_write_i),
    .dcache_address_i(dcache_address_i), .dcache_line_i(dcache_line_i),
    .dcache_line_o(dcache_line_o), .dcache_resp_o(dcache_resp_o),
    .pmem_read_o(pmem_read_o), .pmem_write_o(pmem_write_o),
    .pmem_address_o(pmem_address_o), .pmem_line_o(pmem_line_o),
    .pmem_line_i(pmem_line_i), .pmem_resp_i(pmem_resp_i)
  );

  // One row = one clock cycle: inputs held for the cycle, expected outputs
  // observed in that same cycle. Line fields are codes into lines[].
  typedef struct {
    int rst, ir, ia, dr, dw, da, dl, pr, pl;
    int rd, wr, addr, pln, irs, drs, il, dln;
  } vec_t;

  localparam int NV = 40;
  vec_t         tbl [NV];
  logic [255:0] lines [5];
  int           tests = 0;
  int           fails = 0;
  logic         both_seen = 1'b0;

  task automatic chk(input string nm, input int row, input logic [255:0] act,
                     input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
    end
  endtask

  // icache_resp_o and dcache_resp_o must never be high together.
  always @(negedge clk) begin
    #2;
    if (icache_resp_o && dcache_resp_o) both_seen = 1'b1;
  end

  initial begin
    int k, n;
    lines[0] = '0;
    lines[1] = {8{32'h1111_AAAA}};
    lines[2] = {8{32'h2222_BBBB}};
    lines[3] = {16'hDEAD, {14{16'h5A5A}}, 16'hBEEF};
    lines[4] = ~lines[3];

    //            rst ir ia       dr dw da       dl pr pl  rd wr addr     pln irs drs il dl
    // single I read @0x1000, spurious resp in GAP and IDLE
    tbl[0]  = '{1, 1, 'h1000, 0, 0, 0,      0, 1, 1,  0, 0, 0,      0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 'h1000, 0, 0, 0,      0, 0, 0,  0, 0, 0,      0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 'h1000, 0, 0, 0,      0, 0, 0,  1, 0, 'h1000, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 'h1000, 0, 0, 0,      0, 0, 0,  1, 0, 'h1000, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 'h1000, 0, 0, 0,      0, 0, 0,  1, 0, 'h1000, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 'h1000, 0, 0, 0,      0, 1, 1,  1, 0, 'h1000, 0, 1, 0, 1, 0};
    tbl[6]  = '{0, 0, 0,      0, 0, 0,      0, 1, 2,  0, 0, 'h1000, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 0,      0, 0, 0,      0, 1, 2,  0, 0, 'h1000, 0, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 0,      0, 0, 0,      0, 0, 0,  0, 0, 'h1000, 0, 0, 0, 0, 0};
    // reset, then I/D tie: I first, D after GAP; next tie goes to D
    tbl[9]  = '{1, 0, 0,      0, 0, 0,      0, 0, 0,  0, 0, 0,      0, 0, 0, 0, 0};
    tbl[10] = '{0, 1, 'h3000, 1, 0, 'h4000, 0, 0, 0,  0, 0, 0,      0, 0, 0, 0, 0};
    tbl[11] = '{0, 1, 'h3000, 1, 0, 'h4000, 0, 1, 1,  1, 0, 'h3000, 0, 1, 0, 1, 0};
    tbl[12] = '{0, 0, 0,      1, 0, 'h4000, 0, 0, 0,  0, 0, 'h3000, 0, 0, 0, 0, 0};
    tbl[13] = '{0, 1, 'h5000, 1, 0, 'h4000, 0, 0, 0,  0, 0, 'h3000, 0, 0, 0, 0, 0};
    tbl[14] = '{0, 1, 'h5000, 1, 0, 'h4000, 0, 1, 2,  1, 0, 'h4000, 0, 0, 1, 0, 2};
    tbl[15] = '{0, 1, 'h5000, 0, 0, 0,      0, 0, 0,  0, 0, 'h4000, 0, 0, 0, 0, 0};
    tbl[16] = '{0, 1, 'h5000, 0, 0, 0,      0, 0, 0,  0, 0, 'h4000, 0, 0, 0, 0, 0};
    tbl[17] = '{0, 1, 'h5000, 0, 0, 0,      0, 1, 1,  1, 0, 'h5000, 0, 1, 0, 1, 0};
    tbl[18] = '{0, 0, 0,      0, 0, 0,      0, 0, 0,  0, 0, 'h5000, 0, 0, 0, 0, 0};
    // D write @0x2040, line changes mid-transfer
    tbl[19] = '{0, 0, 0,      0, 1, 'h2040, 3, 0, 0,  0, 0, 'h5000, 0, 0, 0, 0, 0};
    tbl[20] = '{0, 0, 0,      0, 1, 'h2040, 4, 0, 0,  0, 1, 'h2040, 3, 0, 0, 0, 0};
    tbl[21] = '{0, 0, 0,      0, 1, 'h2040, 4, 1, 2,  0, 1, 'h2040, 3, 0, 1, 0, 0};
    tbl[22] = '{0, 0, 0,      0, 0, 0,      4, 0, 0,  0, 0, 'h2040, 3, 0, 0, 0, 0};
    // D read+write together: write first, read after GAP
    tbl[23] = '{0, 0, 0,      1, 1, 'h6000, 4, 0, 0,  0, 0, 'h2040, 3, 0, 0, 0, 0};
    tbl[24] = '{0, 0, 0,      1, 1, 'h6000, 4, 1, 1,  0, 1, 'h6000, 4, 0, 1, 0, 0};
    tbl[25] = '{0, 0, 0,      1, 0, 'h6000, 4, 0, 0,  0, 0, 'h6000, 4, 0, 0, 0, 0};
    tbl[26] = '{0, 0, 0,      1, 0, 'h6000, 4, 0, 0,  0, 0, 'h6000, 4, 0, 0, 0, 0};
    tbl[27] = '{0, 0, 0,      1, 0, 'h6000, 4, 0, 0,  1, 0, 'h6000, 4, 0, 0, 0, 0};
    tbl[28] = '{0, 0, 0,      1, 0, 'h6000, 4, 1, 2,  1, 0, 'h6000, 4, 0, 1, 0, 2};
    tbl[29] = '{0, 0, 0,      0, 0, 0,      4, 0, 0,  0, 0, 'h6000, 4, 0, 0, 0, 0};
    // I read leaves pmem_line_o at the last latched D line
    tbl[30] = '{0, 1, 'h7000, 0, 0, 0,      3, 0, 0,  0, 0, 'h6000, 4, 0, 0, 0, 0};
    tbl[31] = '{0, 1, 'h7000, 0, 0, 0,      3, 1, 1,  1, 0, 'h7000, 4, 1, 0, 1, 0};
    tbl[32] = '{0, 0, 0,      0, 0, 0,      0, 0, 0,  0, 0, 'h7000, 4, 0, 0, 0, 0};
    // reset during SERVE_D aborts, then a fresh I request
    tbl[33] = '{0, 0, 0,      1, 0, 'h8000, 0, 0, 0,  0, 0, 'h7000, 4, 0, 0, 0, 0};
    tbl[34] = '{0, 0, 0,      1, 0, 'h8000, 0, 0, 0,  1, 0, 'h8000, 0, 0, 0, 0, 0};
    tbl[35] = '{1, 0, 0,      1, 0, 'h8000, 0, 1, 2,  0, 0, 0,      0, 0, 0, 0, 0};
    tbl[36] = '{0, 0, 0,      0, 0, 0,      0, 0, 0,  0, 0, 0,      0, 0, 0, 0, 0};
    tbl[37] = '{0, 1, 'h9000, 0, 0, 0,      0, 0, 0,  0, 0, 0,      0, 0, 0, 0, 0};
    tbl[38] = '{0, 1, 'h9000, 0, 0, 0,      0, 1, 1,  1, 0, 'h9000, 0, 1, 0, 1, 0};
    tbl[39] = '{0, 0, 0,      0, 0, 0,      0, 0, 0,  0, 0, 'h9000, 0, 0, 0, 0, 0};

    rst = 1'b1;
    icache_read_i = 1'b0; icache_address_i = '0;
    dcache_read_i = 1'b0; dcache_write_i = 1'b0;
    dcache_address_i = '0; dcache_line_i = '0;
    pmem_line_i = '0; pmem_resp_i = 1'b0;
    repeat (2) @(posedge clk);

    for (int r = 0; r < NV; r++) begin
      @(negedge clk);
      rst              = tbl[r].rst[0];
      icache_read_i    = tbl[r].ir[0];
      icache_address_i = tbl[r].ia;
      dcache_read_i    = tbl[r].dr[0];
      dcache_write_i   = tbl[r].dw[0];
      dcache_address_i = tbl[r].da;
      dcache_line_i    = lines[tbl[r].dl];
      pmem_resp_i      = tbl[r].pr[0];
      pmem_line_i      = lines[tbl[r].pl];
      #1;
      chk("pmem_read",    r, 256'(pmem_read_o),    256'(tbl[r].rd));
      chk("pmem_write",   r, 256'(pmem_write_o),   256'(tbl[r].wr));
      chk("pmem_address", r, 256'(pmem_address_o), 256'(tbl[r].addr));
      chk("pmem_line",    r, pmem_line_o,          lines[tbl[r].pln]);
      chk("icache_resp",  r, 256'(icache_resp_o),  256'(tbl[r].irs));
      chk("dcache_resp",  r, 256'(dcache_resp_o),  256'(tbl[r].drs));
      chk("icache_line",  r, icache_line_o,        lines[tbl[r].il]);
      chk("dcache_line",  r, dcache_line_o,        lines[tbl[r].dln]);
    end

    // D read with a variable adaptor delay; grant must come one cycle later
    // and no resp may appear before the adaptor answers.
    @(negedge clk);
    rst = 1'b0; icache_read_i = 1'b0; dcache_write_i = 1'b0;
    pmem_resp_i = 1'b0;
    dcache_read_i = 1'b1; dcache_address_i = 32'h0000_A000;
    #1;
    chk("seq_idle_read", 100, 256'(pmem_read_o), 256'(0));
    k = 0;
    while (!pmem_read_o && k < 5) begin
      @(negedge clk); #1; k++;
    end
    chk("seq_grant_latency", 100, 256'(k), 256'(1));
    chk("seq_address", 100, 256'(pmem_address_o), 256'(32'h0000_A000));
    n = $urandom_range(1, 6);
    for (int c = 0; c < n; c++) begin
      @(negedge clk); #1;
      chk("seq_hold_read", 101 + c, 256'(pmem_read_o), 256'(1));
      chk("seq_no_early_resp", 101 + c, 256'(dcache_resp_o), 256'(0));
    end
    @(negedge clk);
    pmem_resp_i = 1'b1; pmem_line_i = lines[2];
    #1;
    chk("seq_dresp", 110, 256'(dcache_resp_o), 256'(1));
    chk("seq_dline", 110, dcache_line_o, lines[2]);
    chk("seq_iresp", 110, 256'(icache_resp_o), 256'(0));
    @(negedge clk);
    pmem_resp_i = 1'b0; dcache_read_i = 1'b0;
    #1;
    chk("seq_gap_read", 111, 256'(pmem_read_o), 256'(0));
    chk("seq_gap_resp", 111, 256'(dcache_resp_o), 256'(0));
    @(negedge clk); #3;
    chk("resp_exclusive", 112, 256'(both_seen), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
